// File: rtl/alu_share_arbiter_if.sv
// Requester-side bundle for alu_share_arbiter: two request channels,
// two response channels and the shared registered result/zero bus.
// master = requesters (execute stage, address/branch unit), slave = arbiter.
interface alu_share_arbiter_if;
  logic        req0_valid;
  logic        req0_ready;
  logic [2:0]  req0_op;
  logic [31:0] req0_a;
  logic [31:0] req0_b;
  logic        req1_valid;
  logic        req1_ready;
  logic [2:0]  req1_op;
  logic [31:0] req1_a;
  logic [31:0] req1_b;
  logic        rsp0_valid;
  logic        rsp0_ready;
  logic        rsp1_valid;
  logic        rsp1_ready;
  logic [31:0] rsp_result;
  logic        rsp_zero;

  modport master (
    output req0_valid, req0_op, req0_a, req0_b,
    output req1_valid, req1_op, req1_a, req1_b,
    output rsp0_ready, rsp1_ready,
    input  req0_ready, req1_ready,
    input  rsp0_valid, rsp1_valid, rsp_result, rsp_zero
  );

  modport slave (
    input  req0_valid, req0_op, req0_a, req0_b,
    input  req1_valid, req1_op, req1_a, req1_b,
    input  rsp0_ready, rsp1_ready,
    output req0_ready, req1_ready,
    output rsp0_valid, rsp1_valid, rsp_result, rsp_zero
  );
endinterface

// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: round-robin sharing of one combinational 32-bit ALU
// between the execute stage (requester 0) and the address/branch unit
// (requester 1). Operands are held on the ALU for EXEC_CYCLES settle cycles,
// then result and zero flag are registered and returned to the winner.
// Optional macro ALU_ARB_STATS_EN adds saturating per-requester grant
// counters grant0_cnt/grant1_cnt of width CNT_W.
module alu_share_arbiter #(
  parameter int EXEC_CYCLES = 1,
  parameter int CNT_W       = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  alu_share_arbiter_if.slave bus,
  output logic [2:0]         alu_op,
  output logic [31:0]        alu_a,
  output logic [31:0]        alu_b,
  input  logic [31:0]        alu_result,
  input  logic               alu_zero
`ifdef ALU_ARB_STATS_EN
  ,
  output logic [CNT_W-1:0]   grant0_cnt,
  output logic [CNT_W-1:0]   grant1_cnt
`endif
);

  // Elaboration-time guard on parameter ranges.
  if (EXEC_CYCLES < 1 || EXEC_CYCLES > 15 || CNT_W < 1) begin : g_bad_param
    $error("alu_share_arbiter: EXEC_CYCLES must be 1..15 and CNT_W >= 1");
  end

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  localparam logic [3:0] CNT_LOAD = 4'(EXEC_CYCLES - 1);

  state_t      state_reg;
  logic        last_grant_reg;
  logic        grant_id_reg;
  logic [3:0]  cnt_reg;
  logic        rsp0_valid_reg;
  logic        rsp1_valid_reg;
  logic [31:0] rsp_result_reg;
  logic        rsp_zero_reg;
  logic [2:0]  alu_op_reg;
  logic [31:0] alu_a_reg;
  logic [31:0] alu_b_reg;

  logic        pick0;
  logic        pick1;
  logic        rsp_done;

  // Winner selection: only in IDLE; on a tie the requester that did not
  // complete last wins.
  always_comb begin
    pick0 = 1'b0;
    pick1 = 1'b0;
    if (state_reg == IDLE) begin
      if (bus.req0_valid && bus.req1_valid) begin
        pick0 = last_grant_reg;
        pick1 = !last_grant_reg;
      end else begin
        pick0 = bus.req0_valid;
        pick1 = bus.req1_valid;
      end
    end
  end

  // Response handshake of whichever channel currently holds the result.
  assign rsp_done = (rsp0_valid_reg && bus.rsp0_ready) ||
                    (rsp1_valid_reg && bus.rsp1_ready);

  // Main FSM: accept, hold operands while the ALU settles, capture, respond.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= IDLE;
      last_grant_reg <= 1'b1;
      grant_id_reg   <= 1'b0;
      cnt_reg        <= 4'd0;
      rsp0_valid_reg <= 1'b0;
      rsp1_valid_reg <= 1'b0;
      rsp_result_reg <= 32'd0;
      rsp_zero_reg   <= 1'b0;
      alu_op_reg     <= 3'd0;
      alu_a_reg      <= 32'd0;
      alu_b_reg      <= 32'd0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (pick0 || pick1) begin
            alu_op_reg   <= pick1 ? bus.req1_op : bus.req0_op;
            alu_a_reg    <= pick1 ? bus.req1_a  : bus.req0_a;
            alu_b_reg    <= pick1 ? bus.req1_b  : bus.req0_b;
            grant_id_reg <= pick1;
            cnt_reg      <= CNT_LOAD;
            state_reg    <= EXEC;
          end
        end
        EXEC: begin
          if (cnt_reg == 4'd0) begin
            rsp_result_reg <= alu_result;
            rsp_zero_reg   <= alu_zero;
            rsp0_valid_reg <= !grant_id_reg;
            rsp1_valid_reg <= grant_id_reg;
            state_reg      <= RESP;
          end else begin
            cnt_reg <= cnt_reg - 4'd1;
          end
        end
        RESP: begin
          if (rsp_done) begin
            last_grant_reg <= grant_id_reg;
            rsp0_valid_reg <= 1'b0;
            rsp1_valid_reg <= 1'b0;
            state_reg      <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign bus.req0_ready = pick0;
  assign bus.req1_ready = pick1;
  assign bus.rsp0_valid = rsp0_valid_reg;
  assign bus.rsp1_valid = rsp1_valid_reg;
  assign bus.rsp_result = rsp_result_reg;
  assign bus.rsp_zero   = rsp_zero_reg;
  assign alu_op         = alu_op_reg;
  assign alu_a          = alu_a_reg;
  assign alu_b          = alu_b_reg;

`ifdef ALU_ARB_STATS_EN
  logic [1:0] accept_vec;
  assign accept_vec = {pick1, pick0};

  for (genvar gi = 0; gi < 2; gi++) begin : g_stats
    logic [CNT_W-1:0] cnt_reg;
    // Saturating count of accept handshakes for requester gi.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cnt_reg <= '0;
      end else if (accept_vec[gi] && (cnt_reg != '1)) begin
        cnt_reg <= cnt_reg + CNT_W'(1);
      end
    end
  end

  assign grant0_cnt = g_stats[0].cnt_reg;
  assign grant1_cnt = g_stats[1].cnt_reg;
`endif

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Self-checking bench for alu_share_arbiter: directed scenarios followed by
// randomized traffic, checked against a transaction-level timing model.
// The external ALU is modelled with a settle window: its output is corrupted
// until the operands have been stable for EXEC-1 falling edges.
module tb_alu_share_arbiter;
  localparam int EXEC = 3;
`ifdef ALU_ARB_STATS_EN
  localparam int CW = 4;
`else
  localparam int CW = 16;
`endif
  localparam int CNT_MAX = (1 << CW) - 1;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  alu_share_arbiter_if bus();
  logic [2:0]  alu_op;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [31:0] alu_result;
  logic        alu_zero;
`ifdef ALU_ARB_STATS_EN
  logic [CW-1:0] grant0_cnt;
  logic [CW-1:0] grant1_cnt;
`endif

  alu_share_arbiter #(
    .EXEC_CYCLES(EXEC)
`ifdef ALU_ARB_STATS_EN
    , .CNT_W(CW)
`endif
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus),
    .alu_op(alu_op),
    .alu_a(alu_a),
    .alu_b(alu_b),
    .alu_result(alu_result),
    .alu_zero(alu_zero)
`ifdef ALU_ARB_STATS_EN
    , .grant0_cnt(grant0_cnt),
    .grant1_cnt(grant1_cnt)
`endif
  );

  // Reference ALU: add, sub, and, or, xor, sltu, slt, xnor.
  function automatic logic [31:0] alu_fn(logic [2:0] op, logic [31:0] a, logic [31:0] b);
    case (op)
      3'd0: return a + b;
      3'd1: return a - b;
      3'd2: return a & b;
      3'd3: return a | b;
      3'd4: return a ^ b;
      3'd5: return {31'd0, a < b};
      3'd6: return {31'd0, $signed(a) < $signed(b)};
      default: return ~(a ^ b);
    endcase
  endfunction

  logic [2:0]  prev_op;
  logic [31:0] prev_a, prev_b;
  int          stable_cnt = 0;
  always @(negedge clk) begin
    if (alu_op == prev_op && alu_a == prev_a && alu_b == prev_b) begin
      if (stable_cnt < 100) stable_cnt <= stable_cnt + 1;
    end else begin
      stable_cnt <= 0;
    end
    prev_op <= alu_op;
    prev_a  <= alu_a;
    prev_b  <= alu_b;
  end
  assign alu_result = (stable_cnt >= EXEC - 1) ? alu_fn(alu_op, alu_a, alu_b)
                                               : (alu_fn(alu_op, alu_a, alu_b) ^ 32'hA5A5_5A5A);
  assign alu_zero = (alu_result == 32'd0);

  int errors = 0;
  int checks = 0;

  task automatic check_eq(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%h expected=%h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Transaction-level model state.
  int          cyc = 0;
  bit          m_busy = 0;
  int          m_rsp_at = 0;
  bit          m_owner = 0;
  bit          m_last = 1;
  logic [31:0] m_res = 0;
  bit          m_zero = 0;
  logic [2:0]  m_op = 0;
  logic [31:0] m_a = 0, m_b = 0;
  int          m_gcnt [2] = '{0, 0};
  bit          m_acc [2] = '{0, 0};
  bit          drop_on_acc = 1;
  int          last_acc_cyc = -1;
  int          last_hs_cyc = -1;
  int          grants[$];
  logic [31:0] rsp_log[$];

  // One clock cycle: check outputs at the falling edge, predict what the
  // rising edge does, then advance the model and (optionally) the stimulus.
  task automatic step(bit rnd);
    bit          e_r0, e_r1, rv, hs;
    logic [2:0]  p_op;
    logic [31:0] p_a, p_b;
    @(negedge clk);
    e_r0 = !m_busy && bus.req0_valid && (!bus.req1_valid || m_last);
    e_r1 = !m_busy && bus.req1_valid && (!bus.req0_valid || !m_last);
    rv   = m_busy && (cyc >= m_rsp_at);
    check_eq("req0_ready", bus.req0_ready, e_r0);
    check_eq("req1_ready", bus.req1_ready, e_r1);
    check_eq("rsp0_valid", bus.rsp0_valid, rv && !m_owner);
    check_eq("rsp1_valid", bus.rsp1_valid, rv && m_owner);
    if (rv) begin
      check_eq("rsp_result", bus.rsp_result, m_res);
      check_eq("rsp_zero", bus.rsp_zero, m_zero);
    end
    check_eq("alu_op", alu_op, m_op);
    check_eq("alu_a", alu_a, m_a);
    check_eq("alu_b", alu_b, m_b);
`ifdef ALU_ARB_STATS_EN
    check_eq("grant0_cnt", grant0_cnt, m_gcnt[0]);
    check_eq("grant1_cnt", grant1_cnt, m_gcnt[1]);
`endif
    hs = rv && (m_owner ? bus.rsp1_ready : bus.rsp0_ready);
    if (hs) rsp_log.push_back(bus.rsp_result);
    p_op = e_r1 ? bus.req1_op : bus.req0_op;
    p_a  = e_r1 ? bus.req1_a  : bus.req0_a;
    p_b  = e_r1 ? bus.req1_b  : bus.req0_b;
    @(posedge clk);
    cyc++;
    m_acc[0] = e_r0;
    m_acc[1] = e_r1;
    if (e_r0 || e_r1) begin
      m_busy   = 1;
      m_owner  = e_r1;
      m_rsp_at = cyc + EXEC;
      m_op = p_op; m_a = p_a; m_b = p_b;
      m_res  = alu_fn(p_op, p_a, p_b);
      m_zero = (m_res == 32'd0);
      grants.push_back(int'(e_r1));
      last_acc_cyc = cyc - 1;
      if (m_gcnt[e_r1] < CNT_MAX) m_gcnt[e_r1]++;
    end
    if (hs) begin
      m_busy = 0;
      m_last = m_owner;
      last_hs_cyc = cyc - 1;
    end
    #1;
    if (rnd) rand_drive();
    else if (drop_on_acc) begin
      if (m_acc[0]) bus.req0_valid = 1'b0;
      if (m_acc[1]) bus.req1_valid = 1'b0;
    end
  endtask

  task automatic gen(output logic [2:0] op, output logic [31:0] a, output logic [31:0] b);
    op = 3'($urandom_range(0, 7));
    a  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 15)) : $urandom;
    b  = ($urandom_range(0, 5) == 0) ? a : $urandom;
  endtask

  task automatic rand_drive();
    logic [2:0]  op;
    logic [31:0] a, b;
    if (m_acc[0] || !bus.req0_valid) begin
      gen(op, a, b);
      bus.req0_valid = ($urandom_range(0, 2) != 0);
      bus.req0_op = op; bus.req0_a = a; bus.req0_b = b;
    end else if ($urandom_range(0, 15) == 0) bus.req0_valid = 1'b0;
    if (m_acc[1] || !bus.req1_valid) begin
      gen(op, a, b);
      bus.req1_valid = ($urandom_range(0, 2) != 0);
      bus.req1_op = op; bus.req1_a = a; bus.req1_b = b;
    end else if ($urandom_range(0, 15) == 0) bus.req1_valid = 1'b0;
    bus.rsp0_ready = ($urandom_range(0, 3) != 0);
    bus.rsp1_ready = ($urandom_range(0, 3) != 0);
  endtask

  task automatic settle(int budget);
    int k = 0;
    while ((m_busy || bus.req0_valid || bus.req1_valid) && k < budget) begin
      step(0);
      k++;
    end
    if (k >= budget) check_eq("settle_timeout", 32'd1, 32'd0);
  endtask

  // Reset with every output checked as soon as rst_n falls.
  task automatic do_reset();
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check_eq("rst_rsp0_valid", bus.rsp0_valid, 0);
    check_eq("rst_rsp1_valid", bus.rsp1_valid, 0);
    check_eq("rst_rsp_result", bus.rsp_result, 0);
    check_eq("rst_rsp_zero", bus.rsp_zero, 0);
    check_eq("rst_alu_op", alu_op, 0);
    check_eq("rst_alu_a", alu_a, 0);
    check_eq("rst_alu_b", alu_b, 0);
    check_eq("rst_req0_ready", bus.req0_ready, 0);
    check_eq("rst_req1_ready", bus.req1_ready, 0);
`ifdef ALU_ARB_STATS_EN
    check_eq("rst_grant0_cnt", grant0_cnt, 0);
    check_eq("rst_grant1_cnt", grant1_cnt, 0);
`endif
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    cyc++;
    #1;
    m_busy = 0; m_last = 1; m_op = 0; m_a = 0; m_b = 0;
    m_gcnt[0] = 0; m_gcnt[1] = 0; m_acc[0] = 0; m_acc[1] = 0;
  endtask

  task automatic drive_req(int n, logic [2:0] op, logic [31:0] a, logic [31:0] b);
    if (n == 0) begin
      bus.req0_valid = 1'b1; bus.req0_op = op; bus.req0_a = a; bus.req0_b = b;
    end else begin
      bus.req1_valid = 1'b1; bus.req1_op = op; bus.req1_a = a; bus.req1_b = b;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    bus.req0_valid = 0; bus.req0_op = 0; bus.req0_a = 0; bus.req0_b = 0;
    bus.req1_valid = 0; bus.req1_op = 0; bus.req1_a = 0; bus.req1_b = 0;
    bus.rsp0_ready = 1; bus.rsp1_ready = 1;
    @(posedge clk);
    #1;
    do_reset();

    // Single add on requester 0.
    drive_req(0, 3'b000, 32'd7, 32'd5);
    settle(40);
    check_eq("t1_result", bus.rsp_result, 32'd12);
    check_eq("t1_zero", bus.rsp_zero, 0);
    check_eq("t1_latency", last_hs_cyc - last_acc_cyc, EXEC + 1);

    // Subtract to zero on requester 1.
    drive_req(1, 3'b001, 32'h1234, 32'h1234);
    settle(40);
    check_eq("t2_result", bus.rsp_result, 32'd0);
    check_eq("t2_zero", bus.rsp_zero, 1);

    // Round-robin with both requesters continuously valid.
    grants.delete();
    rsp_log.delete();
    drop_on_acc = 0;
    drive_req(0, 3'b011, 32'd1, 32'd2);
    drive_req(1, 3'b011, 32'd4, 32'd8);
    k = 0;
    while (grants.size() < 4 && k < 60) begin step(0); k++; end
    check_eq("t3_budget", k < 60, 1);
    bus.req0_valid = 0; bus.req1_valid = 0;
    drop_on_acc = 1;
    settle(40);
    if (grants.size() >= 4 && rsp_log.size() >= 4) begin
      for (int i = 0; i < 4; i++) begin
        check_eq("t3_grant", grants[i], i % 2);
        check_eq("t3_result", rsp_log[i], (i % 2 == 0) ? 32'd3 : 32'd12);
      end
    end else check_eq("t3_count", rsp_log.size(), 4);

    // Backpressure on response 0 while requester 1 waits.
    bus.rsp0_ready = 0;
    drive_req(0, 3'b000, 32'd10, 32'd20);
    k = 0;
    while (!m_busy && k < 10) begin step(0); k++; end
    drive_req(1, 3'b010, 32'hF0F0, 32'hFF00);
    k = 0;
    while (!(m_busy && cyc >= m_rsp_at) && k < 20) begin step(0); k++; end
    check_eq("t4_reach_resp", k < 20, 1);
    for (int i = 0; i < 5; i++) step(0);
    check_eq("t4_held_result", bus.rsp_result, 32'd30);
    check_eq("t4_req1_blocked", bus.req1_ready, 0);
    bus.rsp0_ready = 1;
    step(0);
    step(0);
    check_eq("t4_gap", last_acc_cyc - last_hs_cyc, 1);
    check_eq("t4_grant", grants[$], 1);
    settle(40);
    check_eq("t4_req1_result", bus.rsp_result, 32'h0000_F000);

    // Signed compare.
    drive_req(0, 3'b110, 32'hFFFF_FFFF, 32'd1);
    settle(40);
    check_eq("t5_result", bus.rsp_result, 32'd1);
    check_eq("t5_zero", bus.rsp_zero, 0);

    // Randomized traffic.
    for (int i = 0; i < 1500; i++) step(1);
    bus.req0_valid = 0; bus.req1_valid = 0;
    bus.rsp0_ready = 1; bus.rsp1_ready = 1;
    drop_on_acc = 1;
    settle(60);
`ifdef ALU_ARB_STATS_EN
    check_eq("stats_sat0", grant0_cnt, CNT_MAX);
    check_eq("stats_sat1", grant1_cnt, CNT_MAX);
`endif

    // Reset in the middle of an operation, then a tie.
    drive_req(0, 3'b000, $urandom, $urandom);
    k = 0;
    while (!m_busy && k < 10) begin step(0); k++; end
    step(0);
    do_reset();
    drive_req(0, 3'b011, 32'd1, 32'd2);
    drive_req(1, 3'b011, 32'd4, 32'd8);
    #1;
    check_eq("t6_tie_req0", bus.req0_ready, 1);
    check_eq("t6_tie_req1", bus.req1_ready, 0);
    step(0);
    bus.req1_valid = 0;
    settle(40);
    check_eq("t6_result", bus.rsp_result, 32'd3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/alu_share_arbiter.md
Name: alu_share_arbiter

Overview:
Shares the single 32-bit combinational ALU between two requesters: requester 0 is the execute stage and requester 1 is the address/branch unit. Each request is accepted through a valid/ready handshake and arbitrated round-robin. The operands and op are held stable on the ALU for a programmable number of settle cycles. Result and zero flag are registered and returned to the granted requester with its own valid/ready handshake. The ALU's operand source selects are tied to the register path externally, so this block drives both operands directly.

Parameters:
EXEC_CYCLES, 1, ALU settle cycles before capture (legal range 1..15)
CNT_W, 16, width of grant counters (optional feature only)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
req0_valid  in  1  requester 0 has an op
req0_ready  out  1  requester 0 op accepted this cycle
req0_op  in  3  ALU op code (3'b000 add .. 3'b111 xnor)
req0_a  in  32  operand A
req0_b  in  32  operand B
req1_valid / req1_ready / req1_op / req1_a / req1_b  same as above for requester 1
rsp0_valid  out  1  result ready for requester 0
rsp0_ready  in  1  requester 0 takes result
rsp1_valid  out  1  result ready for requester 1
rsp1_ready  in  1  requester 1 takes result
rsp_result  out  32  registered ALU result, shared by both response channels
rsp_zero  out  1  registered ALU zero flag
alu_op  out  3  to ALU op select
alu_a  out  32  to ALU operand A
alu_b  out  32  to ALU operand B
alu_result  in  32  from ALU
alu_zero  in  1  from ALU

Behaviour:
- Reset: async on rst_n low.
  - FSM to IDLE.
  - All outputs 0.
  - last_grant=1, so requester 0 wins the first tie.
  - Settle counter 0.
  - Any in-flight op is dropped; no response is issued.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - Winner: only one valid -> that requester; both valid -> the requester != last_grant.
  - reqN_ready=1 combinationally for the winner only, and only in IDLE; both readies 0 when no request is valid.
  - On accept: latch op/a/b into alu_op/alu_a/alu_b registers, record grant_id, load counter=EXEC_CYCLES-1, go to EXEC.
- EXEC:
  - alu_op/alu_a/alu_b are held constant.
  - Counter decrements each cycle.
  - In the cycle the counter is 0, capture alu_result -> rsp_result and alu_zero -> rsp_zero, then go to RESP.
- RESP:
  - rsp{grant_id}_valid=1; the other response valid stays 0.
  - rsp_result and rsp_zero are held until the handshake.
  - On rspN_valid && rspN_ready: set last_grant=grant_id, clear rspN_valid, go to IDLE.
  - No request is accepted in RESP, even in the handshake cycle, so there is one mandatory IDLE cycle between ops.
- alu_* registers retain the last op after completion; they are not cleared. The ALU is combinational, so this is harmless.
- Latency: accept at cycle T -> rspN_valid high at T+1+EXEC_CYCLES. Back-to-back ops are accepted no more often than every EXEC_CYCLES+2 cycles (with immediate rsp_ready).
- A requester must hold valid/op/a/b stable until its ready. Its valid may drop before grant; no op is then issued.
- Response backpressure (rsp_ready low) stalls indefinitely in RESP with all outputs stable.
- Arithmetic: none in this block; results are exactly what the ALU returns for the latched operands.

Optional Feature:
ALU_ARB_STATS_EN:
- Defined: adds outputs grant0_cnt[CNT_W-1:0] and grant1_cnt[CNT_W-1:0].
  - Each increments on its requester's accept handshake.
  - Each saturates at all-ones.
  - Both reset to 0 asynchronously.
- Undefined: ports and counters are absent; all other behaviour is identical.

Test Plan:
1. Single op: req0 op=000, a=7, b=5 -> req0_ready at T, rsp0_valid at T+2 (EXEC_CYCLES=1), rsp_result=12, rsp_zero=0, rsp1_valid=0 throughout.
2. Zero flag: req1 op=001, a=0x1234, b=0x1234 -> rsp1_valid, rsp_result=0, rsp_zero=1.
3. Round-robin: both valid continuously with op=011 (a=1,b=2 / a=4,b=8) -> grants 0,1,0,1, with results 3,12,3,12 routed to the matching rsp channels.
4. Backpressure: hold rsp0_ready=0 for 5 cycles with req1_valid=1 -> rsp0_valid and result stable, req1_ready=0. After the handshake, one IDLE cycle passes, then req1 is accepted.
5. Signed compare, EXEC_CYCLES=3: op=110, a=0xFFFFFFFF, b=1 -> alu_* stable for 3 cycles, rsp_result=1 at T+4.
6. Reset mid-EXEC: assert rst_n=0 during EXEC -> all outputs 0 immediately, no rsp_valid after release, and next tie grants requester 0. With ALU_ARB_STATS_EN: counters 0 after reset and saturate at 0xFFFF when CNT_W=16.
